// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive frame engine (optional 2-of-3 sampling: UART_RX_MAJORITY_VOTE_EN)
module uart_rx_frame #(
  parameter int unsigned data_size = 8,
  parameter logic        EVEN      = 1'b0,
  parameter logic        ODD       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [5:0]           prescale,
  input  logic                 par_en,
  input  logic                 par_type,
  output logic [data_size-1:0] p_data,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 busy
);

  localparam int unsigned BW = (data_size > 1) ? $clog2(data_size) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [5:0]           edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [5:0]           pre_q, pre_d;
  logic                 par_en_q, par_en_d;
  logic                 par_type_q, par_type_d;
  logic [data_size-1:0] shift_q, shift_d;
  logic [data_size-1:0] p_data_q, p_data_d;
  logic                 perr_q, perr_d;
  logic                 data_valid_q, data_valid_d;
  logic                 par_err_q, par_err_d;
  logic                 stp_err_q, stp_err_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic                 vote0_q, vote0_d;
  logic                 vote1_q, vote1_d;
`endif

  logic [5:0] half_edge, res_edge, last_edge;
  logic       bit_val, at_res, at_last, exp_par, prescale_ok;

  // Bit resolution point and resolved line value for the current bit
  always_comb begin
    half_edge   = pre_q >> 1;
    last_edge   = pre_q - 6'd1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    res_edge    = half_edge + 6'd1;
    bit_val     = (vote0_q & vote1_q) | (vote0_q & rx_in) | (vote1_q & rx_in);
`else
    res_edge    = half_edge;
    bit_val     = rx_in;
`endif
    at_res      = (edge_cnt_q == res_edge);
    at_last     = (edge_cnt_q == last_edge);
    exp_par     = (par_type_q == ODD) ? ~(^shift_q) : ^shift_q;
    prescale_ok = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);
  end

  // Frame sequencing: next-state, counters, shifting and result pulses
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = at_last ? 6'd0 : edge_cnt_q + 6'd1;
    bit_cnt_d    = bit_cnt_q;
    pre_d        = pre_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    perr_d       = perr_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    vote0_d      = vote0_q;
    vote1_d      = vote1_q;
    if (state_q != IDLE && edge_cnt_q == half_edge - 6'd1) vote0_d = rx_in;
    if (state_q != IDLE && edge_cnt_q == half_edge)        vote1_d = rx_in;
`endif
    case (state_q)
      IDLE: begin
        edge_cnt_d = 6'd0;
        if (!rx_in) begin
          // This cycle is edge 0 of the start bit; lock the frame format now
          state_d    = START;
          edge_cnt_d = 6'd1;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          pre_d      = prescale_ok ? prescale : 6'd8;
          par_en_d   = par_en;
          par_type_d = (par_type == ODD) ? ODD : EVEN;
        end
      end
      START: begin
        if (at_res && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = 6'd0;
        end else if (at_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_res) shift_d = {bit_val, shift_q[data_size-1:1]};
        if (at_last) begin
          if (bit_cnt_q == BW'(data_size - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (at_res)  perr_d  = (bit_val != exp_par);
        if (at_last) state_d = STOP;
      end
      STOP: begin
        if (at_res) begin
          // Leave at mid-stop so an immediately following start bit is seen
          data_valid_d = !perr_q && bit_val;
          par_err_d    = perr_q;
          stp_err_d    = !bit_val;
          if (!perr_q && bit_val) p_data_d = shift_q;
          state_d      = IDLE;
          edge_cnt_d   = 6'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = 6'd0;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      edge_cnt_q   <= 6'd0;
      bit_cnt_q    <= '0;
      pre_q        <= 6'd8;
      par_en_q     <= 1'b0;
      par_type_q   <= EVEN;
      shift_q      <= '0;
      p_data_q     <= '0;
      perr_q       <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote0_q      <= 1'b1;
      vote1_q      <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      pre_q        <= pre_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      perr_q       <= perr_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote0_q      <= vote0_d;
      vote1_q      <= vote1_d;
`endif
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE = 1;
`else
  localparam int VOTE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       line_q[$];
  int         dv_c[$];
  logic [7:0] dv_d[$];
  int         pe_c[$];
  int         se_c[$];
  logic       busy_h[$];

  always #5 clk = ~clk;

  uart_rx_frame dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .par_type(par_type), .p_data(p_data), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  function automatic int res_edge(input int p);
    return p / 2 + VOTE;
  endfunction

  task automatic push_bits(input logic lvl, input int n);
    repeat (n) line_q.push_back(lvl);
  endtask

  task automatic push_frame(input logic [7:0] d, input int p, input bit pen,
                            input logic par, input logic stop);
    push_bits(1'b0, p);
    for (int i = 0; i < 8; i++) push_bits(d[i], p);
    if (pen) push_bits(par, p);
    push_bits(stop, p);
  endtask

  // Cycle 0 is the first edge that samples line_q[0]; busy_h[n] / pulse cycles use that origin
  task automatic run_line(input int tail, input bit scramble);
    int total;
    total = line_q.size() + tail;
    dv_c.delete(); dv_d.delete(); pe_c.delete(); se_c.delete(); busy_h.delete();
    busy_h.push_back(busy);
    for (int c = 0; c < total; c++) begin
      rx_in = (c < line_q.size()) ? line_q[c] : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (scramble && c == 0) begin
        prescale = 6'd32;
        par_en   = ~par_en;
        par_type = ~par_type;
      end
      busy_h.push_back(busy);
      if (data_valid) begin dv_c.push_back(c + 1); dv_d.push_back(p_data); end
      if (par_err) pe_c.push_back(c + 1);
      if (stp_err) se_c.push_back(c + 1);
    end
    rx_in = 1'b1;
    line_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_in = 1'b0; prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {data_valid, par_err, stp_err, busy});
    end
    tests_run++;
    if (p_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_p_data: got %h expected 00", p_data);
    end
    rst = 1'b0; rx_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_par_err;
    int exp_c, got;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    push_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    run_line(20, 1'b0);
    exp_c = 10 * 8 + res_edge(8) + 1;
    got = (pe_c.size() == 1) ? pe_c[0] : -1;
    tests_run++;
    if (got !== exp_c) begin
      tests_failed++;
      $display("FAIL par_err_cycle: got %0d (count %0d) expected %0d", got, pe_c.size(), exp_c);
    end
    tests_run++;
    if (dv_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL par_err_other_pulses: got dv=%0d se=%0d expected 0", dv_c.size(), se_c.size());
    end
    tests_run++;
    if (p_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL par_err_p_data: got %h expected 00", p_data);
    end
  endtask

  task automatic test_even_parity;
    int exp_c, got;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    push_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    run_line(20, 1'b0);
    exp_c = 10 * 8 + res_edge(8) + 1;
    got = (dv_c.size() == 1) ? dv_c[0] : -1;
    tests_run++;
    if (got !== exp_c) begin
      tests_failed++;
      $display("FAIL even_dv_cycle: got %0d (count %0d) expected %0d", got, dv_c.size(), exp_c);
    end
    tests_run++;
    if (dv_d.size() != 1 || dv_d[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL even_p_data_at_pulse: got %h expected a5", (dv_d.size() > 0) ? dv_d[0] : 8'hxx);
    end
    tests_run++;
    if (pe_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL even_err_pulses: got pe=%0d se=%0d expected 0", pe_c.size(), se_c.size());
    end
    tests_run++;
    if (p_data !== 8'hA5 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_idle_hold: got p_data=%h busy=%b expected a5 0", p_data, busy);
    end
  endtask

  task automatic test_stop_err;
    int exp_c, got;
    prescale = 6'd16; par_en = 1'b0; par_type = 1'b0;
    push_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
    run_line(40, 1'b0);
    exp_c = 9 * 16 + res_edge(16) + 1;
    got = (se_c.size() == 1) ? se_c[0] : -1;
    tests_run++;
    if (got !== exp_c) begin
      tests_failed++;
      $display("FAIL stp_err_cycle: got %0d (count %0d) expected %0d", got, se_c.size(), exp_c);
    end
    tests_run++;
    if (dv_c.size() + pe_c.size() != 0) begin
      tests_failed++;
      $display("FAIL stp_err_other_pulses: got dv=%0d pe=%0d expected 0", dv_c.size(), pe_c.size());
    end
    tests_run++;
    if (busy_h[exp_c] !== 1'b0 || busy_h[exp_c + 1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL stp_err_restart: got busy %b,%b expected 0,1", busy_h[exp_c], busy_h[exp_c + 1]);
    end
    tests_run++;
    if (busy !== 1'b0 || p_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL stp_err_final: got busy=%b p_data=%h expected 0 a5", busy, p_data);
    end
  endtask

  task automatic test_start_glitch;
    int r;
    prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    push_bits(1'b0, 2);
    run_line(20, 1'b0);
    r = res_edge(8);
    tests_run++;
    if (dv_c.size() + pe_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL glitch_pulses: got %0d expected 0", dv_c.size() + pe_c.size() + se_c.size());
    end
    tests_run++;
    if (busy_h[r] !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_busy_before: got %b expected 1 at cycle %0d", busy_h[r], r);
    end
    tests_run++;
    if (busy_h[r + 1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_busy_after: got %b expected 0 at cycle %0d", busy_h[r + 1], r + 1);
    end
  endtask

  task automatic test_back_to_back;
    int exp0, exp1;
    prescale = 6'd16; par_en = 1'b1; par_type = 1'b1;
    push_frame(8'h00, 16, 1'b1, 1'b1, 1'b1);
    push_frame(8'hFF, 16, 1'b1, 1'b1, 1'b1);
    run_line(20, 1'b0);
    exp0 = 10 * 16 + res_edge(16) + 1;
    exp1 = 11 * 16 + exp0;
    tests_run++;
    if (dv_c.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_dv_count: got %0d expected 2", dv_c.size());
    end else begin
      tests_run++;
      if (dv_c[0] !== exp0 || dv_c[1] !== exp1) begin
        tests_failed++;
        $display("FAIL b2b_dv_cycles: got %0d,%0d expected %0d,%0d", dv_c[0], dv_c[1], exp0, exp1);
      end
      tests_run++;
      if (dv_d[0] !== 8'h00 || dv_d[1] !== 8'hFF) begin
        tests_failed++;
        $display("FAIL b2b_data: got %h,%h expected 00,ff", dv_d[0], dv_d[1]);
      end
    end
    tests_run++;
    if (pe_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_err_pulses: got pe=%0d se=%0d expected 0", pe_c.size(), se_c.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int exp_c, got;
    prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    push_bits(1'b0, 8);
    push_bits(1'b0, 8); push_bits(1'b1, 8); push_bits(1'b0, 8);
    push_bits(1'b1, 4);
    run_line(0, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || dv_c.size() + pe_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_pre: got busy=%b pulses=%0d expected 1 0", busy, dv_c.size() + pe_c.size() + se_c.size());
    end
    rst = 1'b1; rx_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({data_valid, par_err, stp_err, busy} !== 4'b0000 || p_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_clear: got flags=%b p_data=%h expected 0000 00", {data_valid, par_err, stp_err, busy}, p_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    run_line(20, 1'b0);
    exp_c = 9 * 8 + res_edge(8) + 1;
    got = (dv_c.size() == 1) ? dv_c[0] : -1;
    tests_run++;
    if (got !== exp_c) begin
      tests_failed++;
      $display("FAIL midrst_next_cycle: got %0d (count %0d) expected %0d", got, dv_c.size(), exp_c);
    end
    tests_run++;
    if (p_data !== 8'h5A || pe_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_next_data: got %h errs=%0d expected 5a 0", p_data, pe_c.size() + se_c.size());
    end
  endtask

  task automatic test_config_capture;
    int exp_c, got;
    prescale = 6'd12; par_en = 1'b0; par_type = 1'b0;
    push_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    run_line(20, 1'b1);
    exp_c = 9 * 8 + res_edge(8) + 1;
    got = (dv_c.size() == 1) ? dv_c[0] : -1;
    tests_run++;
    if (got !== exp_c) begin
      tests_failed++;
      $display("FAIL cfg_dv_cycle: got %0d (count %0d) expected %0d", got, dv_c.size(), exp_c);
    end
    tests_run++;
    if (p_data !== 8'hC3) begin
      tests_failed++;
      $display("FAIL cfg_p_data: got %h expected c3", p_data);
    end
    tests_run++;
    if (pe_c.size() + se_c.size() != 0) begin
      tests_failed++;
      $display("FAIL cfg_err_pulses: got pe=%0d se=%0d expected 0", pe_c.size(), se_c.size());
    end
    prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    test_reset();
    test_par_err();
    test_even_parity();
    test_stop_err();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_config_capture();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
